// File: rtl/vga_pkg.sv
// Shared constants and types for the VRAMS write-port arbiter and fill engine.
package vga_pkg;
    localparam int DEPTH  = 48;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;
    localparam int CPU_AW = 9;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);
    localparam logic [CPU_AW-1:0] DEPTH_C = CPU_AW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fill_state_e;
    typedef enum logic {GNT_CPU, GNT_FILL} grant_e;

    // Next tile index, wrapping at the end of the RAM.
    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_A) ? '0 : a + ADDR_W'(1);
    endfunction
endpackage

// File: rtl/vrams_fill_fsm.sv
// Fill engine: walks a run of tiles, asking the arbiter for one write slot per tile.
module vrams_fill_fsm
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] len_i,
    input  logic [DATA_W-1:0] value_i,
    input  logic              gnt_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o
);
    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic              zdone_q, zdone_d;   // done pulse for a zero-length request
    logic [ADDR_W-1:0] base_m, len_c;

    // Normalise the request: base reduced modulo DEPTH, length clamped to DEPTH.
    assign base_m = (base_i >= DEPTH_A) ? base_i - DEPTH_A : base_i;
    assign len_c  = (len_i > DEPTH_A) ? DEPTH_A : len_i;

    // Next state: start only from IDLE, advance one tile per granted slot.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rem_d   = rem_q;
        val_d   = val_q;
        zdone_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_c != '0) begin
                        state_d = RUN;
                        cur_d   = base_m;
                        rem_d   = len_c;
                        val_d   = value_i;
                    end else begin
                        zdone_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (gnt_i) begin
                    cur_d = wrap_inc(cur_q);
                    rem_d = rem_q - ADDR_W'(1);
                    if (rem_q == ADDR_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            rem_q   <= '0;
            val_q   <= '0;
            zdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            zdone_q <= zdone_d;
        end
    end

    assign req_o  = (state_q == RUN);
    assign addr_o = cur_q;
    assign data_o = val_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE) || zdone_q;
endmodule

// File: rtl/vrams_arbiter.sv
// VRAMS write-port arbiter: one-entry CPU store buffer, round-robin against the fill engine.
module vrams_arbiter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [CPU_AW-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W-1:0] fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              err_ovf,
    output logic              err_addr,
    input  logic              err_clr
);
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    grant_e            last_q;
    logic              mem_we_q, ovf_q, aerr_q, ovf_set;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;

    logic              legal_we, bad_we, cpu_req, gnt_cpu, gnt_fill;
    logic [ADDR_W-1:0] cpu_a, fill_a;
    logic [DATA_W-1:0] cpu_d, fill_d;
    logic              fill_req;

    vrams_fill_fsm u_fsm (
        .clk     (clk),
        .rst     (rst),
        .start_i (fill_start),
        .base_i  (fill_base),
        .len_i   (fill_len),
        .value_i (fill_value),
        .gnt_i   (gnt_fill),
        .req_o   (fill_req),
        .addr_o  (fill_a),
        .data_o  (fill_d),
        .busy_o  (fill_busy),
        .done_o  (fill_done)
    );

    assign legal_we = cpu_we && (cpu_addr < DEPTH_C);
    assign bad_we   = cpu_we && (cpu_addr >= DEPTH_C);

    // An empty buffer is bypassed so an uncontended store reaches the RAM one cycle later.
    assign cpu_req = buf_vld_q || legal_we;
    assign cpu_a   = buf_vld_q ? buf_addr_q : cpu_addr[ADDR_W-1:0];
    assign cpu_d   = buf_vld_q ? buf_data_q : cpu_data;

    // Round-robin: on contention the CPU wins only if the fill had the previous slot.
    assign gnt_cpu  = cpu_req && (!fill_req || last_q == GNT_FILL);
    assign gnt_fill = fill_req && !gnt_cpu;

    // Buffer refill/hold/drop decision.
    always_comb begin
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        ovf_set    = 1'b0;
        if (gnt_cpu) begin
            // Buffered entry drains; a same-cycle store takes its place.
            if (buf_vld_q) begin
                buf_vld_d  = legal_we;
                buf_addr_d = cpu_addr[ADDR_W-1:0];
                buf_data_d = cpu_data;
            end
        end else if (legal_we) begin
            if (buf_vld_q) begin
                ovf_set = 1'b1;
            end else begin
                buf_vld_d  = 1'b1;
                buf_addr_d = cpu_addr[ADDR_W-1:0];
                buf_data_d = cpu_data;
            end
        end
    end

    // Buffer, grant history, registered RAM port and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            last_q     <= GNT_FILL;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            ovf_q      <= 1'b0;
            aerr_q     <= 1'b0;
        end else begin
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            mem_we_q   <= gnt_cpu || gnt_fill;
            if (gnt_cpu) begin
                last_q     <= GNT_CPU;
                mem_addr_q <= cpu_a;
                mem_data_q <= cpu_d;
            end else if (gnt_fill) begin
                last_q     <= GNT_FILL;
                mem_addr_q <= fill_a;
                mem_data_q <= fill_d;
            end
            ovf_q  <= ovf_set || (ovf_q && !err_clr);
            aerr_q <= bad_we  || (aerr_q && !err_clr);
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign err_ovf  = ovf_q;
    assign err_addr = aerr_q;
endmodule

// File: tb/tb_vrams_arbiter.sv
// Self-checking bench: queue-based reference model plus directed and random stimulus.
module tb_vrams_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_we = 1'b0;
    logic [8:0]  cpu_addr = '0;
    logic [15:0] cpu_data = '0;
    logic        fill_start = 1'b0;
    logic [5:0]  fill_base = '0;
    logic [5:0]  fill_len = '0;
    logic [15:0] fill_value = '0;
    logic        err_clr = 1'b0;
    logic        fill_busy, fill_done, mem_we, err_ovf, err_addr;
    logic [5:0]  mem_addr;
    logic [15:0] mem_data;

    int n_chk = 0;
    int n_pass = 0;

    vrams_arbiter dut (
        .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .err_ovf(err_ovf), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [21:0] bufq[$];     // pending CPU store {addr, data}, at most one
    int          fillq[$];    // tile indices still to be written by the fill
    logic [15:0] m_val;
    bit          m_last_cpu;  // previous granted slot went to the CPU
    bit          m_done;      // model is in its one-cycle done phase
    logic        e_we, e_busy, e_done, e_ovf, e_aerr;
    logic [5:0]  e_addr;
    logic [15:0] e_data;

    always @(posedge clk) begin
        bit legal, bad, had_buf, busy_now, cpu_win, fin, zero, ovf_set;
        int n, b;
        logic [21:0] cand;
        if (rst) begin
            bufq.delete(); fillq.delete();
            m_val = '0; m_last_cpu = 0; m_done = 0;
            e_we = 0; e_busy = 0; e_done = 0; e_ovf = 0; e_aerr = 0;
        end else begin
            legal    = cpu_we && (cpu_addr < 48);
            bad      = cpu_we && (cpu_addr >= 48);
            had_buf  = bufq.size() != 0;
            busy_now = fillq.size() != 0 || m_done;
            cand     = had_buf ? bufq[0] : {cpu_addr[5:0], cpu_data};
            cpu_win  = (had_buf || legal) && (fillq.size() == 0 || !m_last_cpu);
            fin = 0; zero = 0; ovf_set = 0; e_we = 0;
            if (cpu_win) begin
                e_we = 1; e_addr = cand[21:16]; e_data = cand[15:0]; m_last_cpu = 1;
                if (had_buf) begin
                    void'(bufq.pop_front());
                    if (legal) bufq.push_back({cpu_addr[5:0], cpu_data});
                end
            end else begin
                if (fillq.size() != 0) begin
                    e_we = 1; e_addr = 6'(fillq.pop_front()); e_data = m_val;
                    m_last_cpu = 0; fin = (fillq.size() == 0);
                end
                if (legal) begin
                    if (had_buf) ovf_set = 1;
                    else bufq.push_back({cpu_addr[5:0], cpu_data});
                end
            end
            if (fill_start && !busy_now) begin
                n = (fill_len > 48) ? 48 : int'(fill_len);
                b = int'(fill_base) % 48;
                if (n == 0) zero = 1;
                for (int i = 0; i < n; i++) fillq.push_back((b + i) % 48);
                m_val = fill_value;
            end
            m_done = fin;
            e_done = fin || zero;
            e_busy = (fillq.size() != 0) || fin;
            e_ovf  = ovf_set || (e_ovf && !err_clr);
            e_aerr = bad || (e_aerr && !err_clr);
        end
        #1;
        chk("mem_we", mem_we, e_we);
        if (e_we) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_data", mem_data, e_data);
        end
        chk("fill_busy", fill_busy, e_busy);
        chk("fill_done", fill_done, e_done);
        chk("err_ovf", err_ovf, e_ovf);
        chk("err_addr", err_addr, e_aerr);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic store(input logic [8:0] a, input logic [15:0] d);
        cpu_we = 1; cpu_addr = a; cpu_data = d; cyc(); cpu_we = 0;
    endtask

    task automatic start(input logic [5:0] b, input logic [5:0] l, input logic [15:0] v);
        fill_start = 1; fill_base = b; fill_len = l; fill_value = v; cyc(); fill_start = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && fill_busy; i++) cyc();
        chk("idle_timeout", fill_busy, 1'b0);
    endtask

    initial begin
        logic [5:0] exp_a [4];
        exp_a[0] = 6'd46; exp_a[1] = 6'd47; exp_a[2] = 6'd0; exp_a[3] = 6'd1;
        cyc(); cyc();
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_busy", fill_busy, 1'b0);
        chk("rst_errs", {err_ovf, err_addr, fill_done}, 3'b000);
        rst = 0; cyc();

        // single store
        store(9'd5, 16'hABCD);
        chk("st_we", mem_we, 1'b1);
        chk("st_addr", mem_addr, 6'd5);
        chk("st_data", mem_data, 16'hABCD);
        cyc();

        // idle fill wrapping the end of the RAM
        start(6'd46, 6'd4, 16'h0F00);
        chk("fill_busy_on", fill_busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("fill_we", mem_we, 1'b1);
            chk("fill_addr", mem_addr, exp_a[i]);
            chk("fill_data", mem_data, 16'h0F00);
        end
        chk("fill_done_pulse", fill_done, 1'b1);
        cyc();
        chk("fill_busy_off", fill_busy, 1'b0);
        chk("fill_done_off", fill_done, 1'b0);

        // contention: three stores land, a fourth while the buffer is held is dropped
        start(6'd0, 6'd10, 16'h1111);
        for (int k = 0; k < 3; k++) store(9'd10, 16'h2000 + 16'(k));
        chk("cont_no_ovf", err_ovf, 1'b0);
        store(9'd11, 16'h3000);
        cyc();
        chk("ovf_set", err_ovf, 1'b1);
        err_clr = 1; cyc(); err_clr = 0;
        chk("ovf_clr", err_ovf, 1'b0);
        wait_idle();
        cyc();

        // illegal addresses
        store(9'd48, 16'h5555);
        chk("bad48_we", mem_we, 1'b0);
        chk("bad48_err", err_addr, 1'b1);
        store(9'h1FF, 16'h6666);
        chk("bad1ff_we", mem_we, 1'b0);
        err_clr = 1; cyc(); err_clr = 0;
        chk("aerr_clr", err_addr, 1'b0);

        // zero-length fill
        start(6'd7, 6'd0, 16'h7777);
        chk("zero_done", fill_done, 1'b1);
        chk("zero_busy", fill_busy, 1'b0);
        chk("zero_we", mem_we, 1'b0);
        cyc();
        chk("zero_done_off", fill_done, 1'b0);

        // start while busy is ignored; base >= DEPTH and len > DEPTH normalised
        start(6'd20, 6'd3, 16'h8888);
        start(6'd40, 6'd5, 16'h9999);
        wait_idle();
        cyc();
        start(6'd50, 6'd60, 16'hAAAA);
        wait_idle();
        cyc();

        // reset during the third write of a 10-tile fill
        start(6'd30, 6'd10, 16'hBBBB);
        cyc(); cyc();
        rst = 1; cyc(); rst = 0;
        chk("rst_mid_busy", fill_busy, 1'b0);
        chk("rst_mid_we", mem_we, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("rst_mid_quiet", {mem_we, fill_done}, 2'b00);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cpu_we     = ($urandom_range(0, 99) < 45);
            cpu_addr   = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(48, 511))
                                                     : 9'($urandom_range(0, 47));
            cpu_data   = 16'($urandom);
            fill_start = ($urandom_range(0, 99) < 6);
            fill_base  = 6'($urandom_range(0, 63));
            fill_len   = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            fill_value = 16'($urandom);
            err_clr    = ($urandom_range(0, 99) < 3);
            rst        = ($urandom_range(0, 999) < 4);
            cyc();
        end
        cpu_we = 0; fill_start = 0; err_clr = 0; rst = 0;
        for (int i = 0; i < 60; i++) cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
